// File: rtl/xorshift_inverse_if.sv
// Start/busy/done handshake bundle between a requester and the xorshift inverter.
interface xorshift_inverse_if #(
   parameter int unsigned W = 16
) ();
   logic         start;
   logic [W-1:0] din;
   logic         busy;
   logic         done;
   logic [W-1:0] dout;

   modport master (
      output start,
      output din,
      input  busy,
      input  done,
      input  dout
   );

   modport slave (
      input  start,
      input  din,
      output busy,
      output done,
      output dout
   );
endinterface

// File: rtl/xorshift_inverse.sv
// Recovers the pre-round xorshift state by undoing the three shift-xor steps in reverse
// order, one fixed-point iteration per clock.
module xorshift_inverse #(
   parameter int unsigned W = 16,
   parameter int unsigned A = 7,
   parameter int unsigned B = 9,
   parameter int unsigned C = 8
) (
   input logic               clk,
   input logic               rst,
   xorshift_inverse_if.slave bus
);

   // Iterations needed for each step to converge: ceil(W/X)-1.
   localparam int unsigned KC   = (W + C - 1) / C - 1;
   localparam int unsigned KB   = (W + B - 1) / B - 1;
   localparam int unsigned KA   = (W + A - 1) / A - 1;
   localparam int unsigned KCB  = (KC > KB) ? KC : KB;
   localparam int unsigned KMax = (KCB > KA) ? KCB : KA;
   localparam int unsigned CntW = $clog2(KMax) + 1;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StUndoC = 3'd1,
      StUndoB = 3'd2,
      StUndoA = 3'd3,
      StDone  = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [W-1:0]      y_q, y_d;
   logic [W-1:0]      t_q, t_d;
   logic [W-1:0]      dout_q, dout_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]      t_new;
   logic              busy;
   logic              done;

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      t_d     = t_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      t_new   = '0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               y_d     = bus.din;
               t_d     = bus.din;
               cnt_d   = '0;
               state_d = StUndoC;
            end
         end
         StUndoC: begin
            busy  = 1'b1;
            t_new = y_q ^ (t_q << C);
            t_d   = t_new;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(KC - 1)) begin
               y_d     = t_new;
               cnt_d   = '0;
               state_d = StUndoB;
            end
         end
         StUndoB: begin
            busy  = 1'b1;
            t_new = y_q ^ (t_q >> B);
            t_d   = t_new;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(KB - 1)) begin
               y_d     = t_new;
               cnt_d   = '0;
               state_d = StUndoA;
            end
         end
         StUndoA: begin
            busy  = 1'b1;
            t_new = y_q ^ (t_q << A);
            t_d   = t_new;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(KA - 1)) begin
               y_d     = t_new;
               cnt_d   = '0;
               dout_d  = t_new;
               state_d = StDone;
            end
         end
         StDone: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         y_q     <= '0;
         t_q     <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         t_q     <= t_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.dout = dout_q;

endmodule

// File: tb/tb_xorshift_inverse.sv
// Randomised and directed round-trip bench for the xorshift inverter.
module tb_xorshift_inverse;

   localparam int unsigned W = 16;
   localparam int unsigned A = 7;
   localparam int unsigned B = 9;
   localparam int unsigned C = 8;
   localparam int unsigned NRand = 1000;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   logic [W-1:0] prev_dout;

   xorshift_inverse_if #(.W(W)) bus ();

   xorshift_inverse #(
      .W(W),
      .A(A),
      .B(B),
      .C(C)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Forward generator round, straight from its definition.
   function automatic logic [W-1:0] fwd(input logic [W-1:0] x);
      logic [W-1:0] v;
      v = x;
      v = v ^ (v << A);
      v = v ^ (v >> B);
      v = v ^ (v << C);
      return v;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input logic [W-1:0] exp_dout);
      check({tag, "_busy"}, W'(bus.busy), '0);
      check({tag, "_done"}, W'(bus.done), '0);
      check({tag, "_dout"}, bus.dout, exp_dout);
   endtask

   // One operation from IDLE; leaves the bench in the first idle cycle after DONE.
   task automatic run_op(input string tag, input logic [W-1:0] d, input logic [W-1:0] exp);
      bus.din   = d;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.din   = W'($urandom);
      for (int k = 1; k <= 5; k++) begin
         check({tag, "_busy"}, W'(bus.busy), 1);
         check({tag, "_done"}, W'(bus.done), W'(k == 5));
         check({tag, "_dout"}, bus.dout, (k == 5) ? exp : prev_dout);
         if (k < 5) tick();
      end
      tick();
      check_idle({tag, "_after"}, exp);
      prev_dout = exp;
   endtask

   initial begin
      logic [W-1:0] q[$];
      logic [W-1:0] x;
      int           last_done;
      int           cyc;
      int           ndone;
      int           got_done;

      n_cmp     = 0;
      n_err     = 0;
      prev_dout = '0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.din   = '0;
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_idle("reset_idle", '0);
      end

      run_op("seed1", 16'h8181, 16'h0001);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("seed1_hold", 16'h0001);
      end
      run_op("seed00ff", 16'h3F40, 16'h00FF);
      run_op("zero", 16'h0000, 16'h0000);
      run_op("ones", fwd(16'hFFFF), 16'hFFFF);
      run_op("msb", fwd(16'h8000), 16'h8000);

      // Start re-asserted while busy must be ignored.
      bus.din   = 16'h8181;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      got_done  = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k >= 2 && k <= 4) begin
            bus.start = 1'b1;
            bus.din   = 16'h3F40;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) got_done++;
         if (k == 5) check("busy_start_dout", bus.dout, 16'h0001);
         if (k == 5) check("busy_start_done5", W'(bus.done), 1);
         tick();
      end
      check("busy_start_ndone", W'(got_done), 1);
      check_idle("busy_start_end", 16'h0001);

      // Reset in the middle of an operation aborts it.
      bus.din   = 16'h3F40;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_idle("midreset", '0);
      got_done = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.done) got_done++;
      end
      check("midreset_nodone", W'(got_done), 0);
      check_idle("midreset_end", '0);

      // Back-to-back round trips with start held high.
      x = W'($urandom);
      q.push_back(x);
      bus.din   = fwd(x);
      bus.start = 1'b1;
      last_done = 0;
      cyc       = 0;
      ndone     = 0;
      while (ndone < NRand) begin
         got_done = 0;
         for (int w = 0; w < 20; w++) begin
            tick();
            cyc++;
            if (bus.done) begin
               got_done = 1;
               break;
            end
         end
         if (got_done == 0) begin
            check("rand_timeout", '0, 1);
            break;
         end
         check("rand_dout", bus.dout, q.pop_front());
         check("rand_spacing", W'(cyc - last_done), (ndone == 0) ? W'(5) : W'(6));
         last_done = cyc;
         ndone++;
         if (ndone < NRand) begin
            x = W'($urandom);
            q.push_back(x);
            bus.din = fwd(x);
         end else begin
            bus.start = 1'b0;
         end
      end
      tick();
      tick();
      check("rand_final_busy", W'(bus.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/xorshift_inverse.md
Name: xorshift_inverse

Overview:
- Inverse of the xorshift random generator: takes a W-bit generator output and recovers the seed (pre-round state) that produced it.
- Undoes the three forward steps in reverse order: x^=x<<C, then x^=x>>B, then x^=x<<A.
- Each step is undone by fixed-point iteration, one term per clock.
- Sits beside the generator in the verification/replay path; uses a start/busy/done handshake matching the generator controller.

Parameters:
W, 16, data width
A, 7, first forward left-shift amount (1 <= A < W)
B, 9, forward right-shift amount (1 <= B < W)
C, 8, last forward left-shift amount (1 <= C < W)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous active-low reset; rst==0 at a rising edge resets the block
start  input  1  request; sampled only in IDLE
din  input  W  generator output to invert; captured on accepted start
busy  output  1  high from the edge after an accepted start until done ends
done  output  1  one-cycle pulse; dout is valid from this cycle
dout  output  W  recovered seed; held until overwritten by the next completion

Behaviour:
- Reset (rst==0 at an edge), regardless of state: state=IDLE, busy=0, done=0, dout=0, internal y/t/cnt=0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- Iteration counts: kX = ceil(W/X)-1 for X in {C,B,A}. Defaults: kC=1, kB=1, kA=2.
- Registers: y = stage input, t = running estimate, cnt = iteration counter (width clog2(max k)+1).
- States: IDLE, UNDO_C, UNDO_B, UNDO_A, DONE.
- IDLE: busy=0, done=0. On start==1: y<=din, t<=din, cnt<=0, go to UNDO_C.
- UNDO_C: each cycle t<=y^(t<<C) (logical shift, truncated to W), cnt<=cnt+1. On the cycle cnt==kC-1: y<=t_new, t<=t_new, cnt<=0, go to UNDO_B.
- UNDO_B: same, with t<=y^(t>>B) (logical, zero-fill), count kB. Next state is UNDO_A.
- UNDO_A: same, with t<=y^(t<<A), count kA. On the final iteration: dout<=t_new, go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then unconditionally IDLE.
- Latency: done is high in the cycle after edge number 1+kC+kB+kA, where the start-sampling edge is edge 1. Default: 5 edges, so done is high in cycle 5 after start.
- Back-to-back throughput: one result per 2+kC+kB+kA cycles (start may be re-asserted in the cycle after DONE).
- start while busy (UNDO_*/DONE): ignored, din not sampled, no queuing.
- start held continuously: a new operation starts each time IDLE is reached.
- dout is unchanged during an operation until the DONE transition. Previous result stays visible while busy.
- busy and done are registered decodes of state; no combinational path from start/din to any output.
- Unused/illegal state encodings: next state IDLE, outputs as IDLE.
- Correctness requirement: for every W-bit x, dout == x when din == fwd(x), where fwd(x) is the three-step xorshift round with (A,B,C).

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release, start=0 -> busy=0, done=0, dout=0x0000 indefinitely.
- Seed 1: din=0x8181, start pulse -> busy high for cycles 1..5, done high only in cycle 5, dout=0x0001 from cycle 5 and held after.
- Seed 0x00FF: din=0x3F40 -> dout=0x00FF at done. Zero: din=0x0000 -> dout=0x0000.
- Start during busy: start with din=0x8181, then start=1 with din=0x3F40 in cycles 2-4 -> single done in cycle 5, dout=0x0001. A second operation begins only once IDLE accepts start.
- Reset mid-op: start din=0x3F40, rst=0 in cycle 3 -> no done pulse, busy=0, dout=0x0000 the cycle after reset.
- Randomised round trip: 1000 random seeds x, din=fwd(x) from the reference model, start held high -> every done shows dout==x, spacing exactly 6 cycles.
